// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared encodings for the pipeline run controller: host commands, run states,
// stop causes and the retiring opcode that signals a halt instruction.
package pipeline_run_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_CLR_CNT = 3'b000,
        OP_RUN     = 3'b001,
        OP_STEP    = 3'b010,
        OP_HALT    = 3'b011,
        OP_SET_BP  = 3'b100,
        OP_CLR_BP  = 3'b101,
        OP_NOP0    = 3'b110,
        OP_NOP1    = 3'b111
    } cmdOp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } runState_e;

    typedef enum logic [1:0] {
        SC_STEP_DONE  = 2'b00,
        SC_BREAKPOINT = 2'b01,
        SC_HALT_INSTR = 2'b10,
        SC_HOST_HALT  = 2'b11
    } stopCause_e;

    localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_run_ctrl_run_ctr.sv
// Saturating up-counter with synchronous clear; counts enabled pipeline cycles.
module run_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (en && !(&count))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step/breakpoint controller: gates the pipeline clock enable and reports
// why the pipeline stopped.
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    input  logic [31:0] pc_if,
    input  logic        halt_detect,
    output logic        pipe_en,
    output logic [1:0]  state,
    output logic [31:0] cycle_count,
    output logic        done,
    output logic [1:0]  stop_cause
);

    runState_e   curState, nxtState;
    stopCause_e  causeQ, causeNxt;
    logic [31:0] stepRem, bpAddr;
    logic        bpValid, firstRun, doneQ;
    logic        cmdAcc, idleAcc, hostHalt, bpHit, stopNow, stepLast;

    assign cmdAcc   = cmd_valid & cmd_ready;
    assign idleAcc  = cmdAcc & (curState == ST_IDLE);
    assign hostHalt = cmdAcc & (cmd_op == OP_HALT) & (curState != ST_IDLE);
    assign bpHit    = bpValid & (pc_if == bpAddr);
    assign stepLast = (curState == ST_STEP) & pipe_en & (stepRem == 32'd1);

    // The first RUN cycle ignores halt/breakpoint so a resume moves off the stop point.
    always_comb begin
        stopNow = 1'b0;
        if (curState == ST_RUN)
            stopNow = hostHalt | (!firstRun & (halt_detect | bpHit));
        else if (curState == ST_STEP)
            stopNow = hostHalt;
    end

    always_comb begin
        causeNxt = SC_STEP_DONE;
        if (hostHalt)
            causeNxt = SC_HOST_HALT;
        else if (curState == ST_RUN && halt_detect)
            causeNxt = SC_HALT_INSTR;
        else if (curState == ST_RUN && bpHit)
            causeNxt = SC_BREAKPOINT;
    end

    always_ff @(posedge clk) begin
        if (reset)
            curState <= ST_IDLE;
        else
            curState <= nxtState;
    end

    always_comb begin
        nxtState = curState;
        case (curState)
            ST_IDLE: begin
                if (cmdAcc && cmd_op == OP_RUN)
                    nxtState = ST_RUN;
                else if (cmdAcc && cmd_op == OP_STEP)
                    nxtState = ST_STEP;
            end
            ST_RUN:  if (stopNow) nxtState = ST_IDLE;
            ST_STEP: if (stopNow || stepLast) nxtState = ST_IDLE;
            default: nxtState = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (curState == ST_IDLE) | (cmd_op == OP_HALT);
        pipe_en   = (curState != ST_IDLE) & !stopNow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stepRem  <= '0;
            bpAddr   <= '0;
            bpValid  <= 1'b0;
            firstRun <= 1'b0;
            doneQ    <= 1'b0;
            causeQ   <= SC_STEP_DONE;
        end else begin
            doneQ    <= 1'b0;
            firstRun <= idleAcc & (cmd_op == OP_RUN);
            if (curState != ST_IDLE && nxtState == ST_IDLE) begin
                doneQ  <= 1'b1;
                causeQ <= causeNxt;
            end
            if (idleAcc) begin
                case (cmd_op)
                    OP_STEP:   stepRem <= (cmd_arg == '0) ? 32'd1 : cmd_arg;
                    OP_SET_BP: begin
                        bpAddr  <= cmd_arg;
                        bpValid <= 1'b1;
                    end
                    OP_CLR_BP: bpValid <= 1'b0;
                    default: ;
                endcase
            end else if (curState == ST_STEP && pipe_en) begin
                stepRem <= stepRem - 32'd1;
            end
        end
    end

    run_ctr #(.W(32)) uCtr (
        .clk   (clk),
        .reset (reset),
        .clr   (idleAcc && cmd_op == OP_CLR_CNT),
        .en    (pipe_en),
        .count (cycle_count)
    );

    assign state      = curState;
    assign done       = doneQ;
    assign stop_cause = causeQ;

endmodule
